// File: rtl/slow_clock_pkg.sv
// Shared types and defaults for the slow-clock controller and its period counter.
package slow_clock_pkg;

  localparam int CNT_W_DEF   = 20;
  localparam int BURST_W_DEF = 16;

  localparam logic [CNT_W_DEF-1:0] DEF_PERIOD = 20'd49999;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_e;

  typedef struct packed {
    logic [CNT_W_DEF-1:0]   period;
    logic [BURST_W_DEF-1:0] burst;
  } cfg_t;

endpackage

// File: rtl/slow_clock_ctrl_period_counter.sv
// Loadable wrap counter: counts 0..period and restarts; clr forces zero.
module period_counter #(
  parameter int CNT_W = 20
) (
  input  logic             fastclock,
  input  logic             reset,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] period_i,
  output logic [CNT_W-1:0] count_o,
  output logic             wrap_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign wrap_o  = (count_q == period_i);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i)     count_d = '0;
    else if (en_i) count_d = wrap_o ? '0 : count_q + CNT_W'(1);
  end

  always_ff @(posedge fastclock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/slow_clock_ctrl.sv
// Run/stop/burst controller around a period counter, with a one-deep config slot
// that is applied immediately in IDLE and only on a period wrap while running.
module slow_clock_ctrl
  import slow_clock_pkg::*;
#(
  parameter int               CNT_W          = CNT_W_DEF,
  parameter int               BURST_W        = BURST_W_DEF,
  parameter logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(DEF_PERIOD)
) (
  input  logic               fastclock,
  input  logic               reset,
  // cfg handshake: a transfer happens on any edge where cfg_valid && cfg_ready;
  // cfg_valid may be raised or dropped freely, cfg_ready never depends on it.
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               start,
  input  logic               stop,
  output logic               tick,
  output logic               slowclock,
  output logic               running,
  output logic               done,
  output logic [1:0]         state_dbg
);

  state_e             state_q;
  logic [CNT_W-1:0]   p_q;
  logic [BURST_W-1:0] b_q;
  logic [CNT_W-1:0]   pend_period_q;
  logic [BURST_W-1:0] pend_burst_q;
  logic               pend_valid_q;
  logic [BURST_W-1:0] remaining_q;
  logic               done_q;

  logic [CNT_W-1:0]   count;
  logic               wrap;
  logic               xfer;
  logic [CNT_W-1:0]   cfg_period_d;

  period_counter #(.CNT_W(CNT_W)) u_period_counter (
    .fastclock (fastclock),
    .reset     (reset),
    .en_i      (running),
    .clr_i     (state_q == IDLE),
    .period_i  (p_q),
    .count_o   (count),
    .wrap_o    (wrap)
  );

  assign running      = (state_q != IDLE);
  assign tick         = running && wrap;
  assign slowclock    = running && (count <= (p_q >> 1));
  assign cfg_ready    = !pend_valid_q;
  assign done         = done_q;
  assign state_dbg    = state_q;
  assign xfer         = cfg_valid && cfg_ready;
  assign cfg_period_d = (cfg_period == '0) ? CNT_W'(1) : cfg_period;

  always_ff @(posedge fastclock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      p_q           <= DEFAULT_PERIOD;
      b_q           <= '0;
      pend_period_q <= '0;
      pend_burst_q  <= '0;
      pend_valid_q  <= 1'b0;
      remaining_q   <= '0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (xfer) begin
        pend_period_q <= cfg_period_d;
        pend_burst_q  <= cfg_burst;
        pend_valid_q  <= 1'b1;
      end

      // Swapping P only at the wrap keeps every slowclock phase whole.
      if (pend_valid_q && (state_q == IDLE || tick)) begin
        p_q          <= pend_period_q;
        b_q          <= pend_burst_q;
        pend_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= RUN;
            remaining_q <= b_q;
          end
        end
        RUN, STOPPING: begin
          if (tick) begin
            // remaining is zero for continuous runs and is then left alone.
            if (remaining_q != '0) remaining_q <= remaining_q - BURST_W'(1);
            if (remaining_q == BURST_W'(1)) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else if (stop || state_q == STOPPING) begin
              state_q <= IDLE;
            end
          end else if (stop && state_q == RUN) begin
            state_q <= STOPPING;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slow_clock_ctrl.sv
// Directed bench for slow_clock_ctrl; DEFAULT_PERIOD is shortened to 11 to keep runs brief.
module tb_slow_clock_ctrl;
  import slow_clock_pkg::*;

  localparam logic [19:0] DEF_P = 20'd11;

  logic        fastclock;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [19:0] cfg_period;
  logic [15:0] cfg_burst;
  logic        start;
  logic        stop;
  logic        tick;
  logic        slowclock;
  logic        running;
  logic        done;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  slow_clock_ctrl #(.CNT_W(20), .BURST_W(16), .DEFAULT_PERIOD(DEF_P)) dut (
    .fastclock  (fastclock),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_burst  (cfg_burst),
    .start      (start),
    .stop       (stop),
    .tick       (tick),
    .slowclock  (slowclock),
    .running    (running),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  initial fastclock = 1'b0;
  always #5 fastclock = ~fastclock;

  // Advance one clock; outputs are read and inputs changed 1 time unit after the edge.
  task automatic cyc();
    @(posedge fastclock);
    #1;
  endtask

  task automatic load_cfg(input cfg_t c);
    cfg_valid  = 1'b1;
    cfg_period = c.period;
    cfg_burst  = c.burst;
    cyc();
    cfg_valid = 1'b0;
    cyc();
  endtask

  // Returns in the first cycle of the run (count == 0).
  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic stop_run(input int budget);
    int n;
    n = 0;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    while (running === 1'b1 && n < budget) begin
      cyc();
      n++;
    end
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL stop_run: running=%b required 0 within %0d cycles", running, budget);
    end
  endtask

  task automatic test_reset();
    int first;
    int highs;
    reset = 1'b1;
    cyc();
    cyc();
    checks += 6;
    if (tick !== 1'b0)      begin errors++; $display("FAIL reset_tick: got %b required 0", tick); end
    if (slowclock !== 1'b0) begin errors++; $display("FAIL reset_slowclock: got %b required 0", slowclock); end
    if (running !== 1'b0)   begin errors++; $display("FAIL reset_running: got %b required 0", running); end
    if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b required 1", cfg_ready); end
    if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d required 0", state_dbg); end
    reset = 1'b0;
    cyc();
    pulse_start();
    first = -1;
    highs = 0;
    for (int i = 0; i < 12; i++) begin
      if (tick === 1'b1 && first < 0) first = i;
      if (slowclock === 1'b1) highs++;
      cyc();
    end
    checks += 2;
    if (first != 11) begin errors++; $display("FAIL default_period_tick: first tick at %0d required 11", first); end
    if (highs != 6)  begin errors++; $display("FAIL default_period_high: high %0d cycles required 6", highs); end
    stop_run(20);
  endtask

  task automatic test_continuous();
    cfg_valid  = 1'b1;
    cfg_period = 20'd9;
    cfg_burst  = 16'd0;
    cyc();
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cont_ready_low: got %b required 0", cfg_ready); end
    cyc();
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL cont_ready_high: got %b required 1", cfg_ready); end
    pulse_start();
    for (int i = 0; i < 30; i++) begin
      checks += 4;
      if (tick !== (i % 10 == 9))       begin errors++; $display("FAIL cont_tick i=%0d: got %b required %b", i, tick, (i % 10 == 9)); end
      if (slowclock !== (i % 10 <= 4))  begin errors++; $display("FAIL cont_slow i=%0d: got %b required %b", i, slowclock, (i % 10 <= 4)); end
      if (running !== 1'b1)             begin errors++; $display("FAIL cont_running i=%0d: got %b required 1", i, running); end
      if (done !== 1'b0)                begin errors++; $display("FAIL cont_done i=%0d: got %b required 0", i, done); end
      cyc();
    end
    stop_run(12);
  endtask

  task automatic test_burst();
    load_cfg('{period: 20'd3, burst: 16'd4});
    pulse_start();
    for (int i = 0; i < 24; i++) begin
      checks += 3;
      if (tick !== (i < 16 && i % 4 == 3)) begin errors++; $display("FAIL burst_tick i=%0d: got %b required %b", i, tick, (i < 16 && i % 4 == 3)); end
      if (done !== (i == 16))              begin errors++; $display("FAIL burst_done i=%0d: got %b required %b", i, done, (i == 16)); end
      if (running !== (i < 16))            begin errors++; $display("FAIL burst_running i=%0d: got %b required %b", i, running, (i < 16)); end
      cyc();
    end
  endtask

  task automatic test_reconfig();
    logic exp_slow;
    load_cfg('{period: 20'd9, burst: 16'd0});
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      exp_slow = (i < 10) ? (i <= 4) : ((i - 10) % 5 <= 2);
      checks += 3;
      if (tick !== (i == 9 || i == 14 || i == 19)) begin errors++; $display("FAIL reconf_tick i=%0d: got %b required %b", i, tick, (i == 9 || i == 14 || i == 19)); end
      if (slowclock !== exp_slow)                  begin errors++; $display("FAIL reconf_slow i=%0d: got %b required %b", i, slowclock, exp_slow); end
      if (cfg_ready !== !(i >= 4 && i <= 9))       begin errors++; $display("FAIL reconf_ready i=%0d: got %b required %b", i, cfg_ready, !(i >= 4 && i <= 9)); end
      cfg_valid  = (i == 3);
      cfg_period = 20'd4;
      cfg_burst  = 16'd0;
      cyc();
    end
    cfg_valid = 1'b0;
    stop_run(8);
  endtask

  task automatic test_stop();
    int first;
    load_cfg('{period: 20'd7, burst: 16'd0});
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      checks += 3;
      if (tick !== (i == 7))    begin errors++; $display("FAIL stop_tick i=%0d: got %b required %b", i, tick, (i == 7)); end
      if (running !== (i <= 7)) begin errors++; $display("FAIL stop_running i=%0d: got %b required %b", i, running, (i <= 7)); end
      if (done !== 1'b0)        begin errors++; $display("FAIL stop_done i=%0d: got %b required 0", i, done); end
      stop = (i == 2);
      cyc();
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    checks += 2;
    if (running !== 1'b0)   begin errors++; $display("FAIL idle_stop_running: got %b required 0", running); end
    if (state_dbg !== 2'd0) begin errors++; $display("FAIL idle_stop_state: got %0d required 0", state_dbg); end
    pulse_start();
    first = -1;
    for (int i = 0; i < 9; i++) begin
      if (tick === 1'b1 && first < 0) first = i;
      cyc();
    end
    checks++;
    if (first != 7) begin errors++; $display("FAIL idle_stop_restart: first tick at %0d required 7", first); end
    stop_run(10);
  endtask

  task automatic test_clamp();
    load_cfg('{period: 20'd0, burst: 16'd0});
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      checks += 2;
      if (slowclock !== (i % 2 == 0)) begin errors++; $display("FAIL clamp_slow i=%0d: got %b required %b", i, slowclock, (i % 2 == 0)); end
      if (tick !== (i % 2 == 1))      begin errors++; $display("FAIL clamp_tick i=%0d: got %b required %b", i, tick, (i % 2 == 1)); end
      cyc();
    end
    stop_run(4);
  endtask

  task automatic test_stop_final_tick();
    load_cfg('{period: 20'd1, burst: 16'd2});
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      checks += 3;
      if (tick !== (i == 1 || i == 3)) begin errors++; $display("FAIL final_stop_tick i=%0d: got %b required %b", i, tick, (i == 1 || i == 3)); end
      if (done !== (i == 4))           begin errors++; $display("FAIL final_stop_done i=%0d: got %b required %b", i, done, (i == 4)); end
      if (running !== (i <= 3))        begin errors++; $display("FAIL final_stop_running i=%0d: got %b required %b", i, running, (i <= 3)); end
      stop = (i == 3);
      cyc();
    end
    stop = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int first;
    load_cfg('{period: 20'd9, burst: 16'd5});
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      cfg_valid  = (i == 4);
      cfg_period = 20'd2;
      cfg_burst  = 16'd0;
      cyc();
    end
    cfg_valid = 1'b0;
    checks += 2;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL midrun_pending: cfg_ready=%b required 0", cfg_ready); end
    if (running !== 1'b1)   begin errors++; $display("FAIL midrun_running: got %b required 1", running); end
    reset = 1'b1;
    #1;
    checks += 5;
    if (tick !== 1'b0)      begin errors++; $display("FAIL midrun_rst_tick: got %b required 0", tick); end
    if (slowclock !== 1'b0) begin errors++; $display("FAIL midrun_rst_slow: got %b required 0", slowclock); end
    if (running !== 1'b0)   begin errors++; $display("FAIL midrun_rst_running: got %b required 0", running); end
    if (done !== 1'b0)      begin errors++; $display("FAIL midrun_rst_done: got %b required 0", done); end
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL midrun_rst_ready: got %b required 1", cfg_ready); end
    cyc();
    reset = 1'b0;
    cyc();
    pulse_start();
    first = -1;
    for (int i = 0; i < 13; i++) begin
      if (tick === 1'b1 && first < 0) first = i;
      cyc();
    end
    checks++;
    if (first != 11) begin errors++; $display("FAIL midrun_default_p: first tick at %0d required 11", first); end
    stop_run(15);
  endtask

  initial begin
    reset      = 1'b1;
    cfg_valid  = 1'b0;
    cfg_period = '0;
    cfg_burst  = '0;
    start      = 1'b0;
    stop       = 1'b0;
    test_reset();
    test_continuous();
    test_burst();
    test_reconfig();
    test_stop();
    test_clamp();
    test_stop_final_tick();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
